fifo_qam_symbol_reader: RTL and testbench



---
 rtl/qam_pkg.sv | 15 +
 rtl/qam_gray_map.sv | 16 +
 rtl/fifo_qam_symbol_reader.sv | 80 ++++++++
 tb/tb_fifo_qam_symbol_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared constants and the per-axis Gray helper for the 64-QAM symbol reader.
// The QAM_GRAY_EN macro selects Gray-coded symbol output in qam_gray_map.
package qam_pkg;

    localparam int DATA_W = 8;
    localparam int SYM_W  = 6;
    localparam int AXIS_W = 3;
    localparam int BUF_W  = DATA_W + SYM_W - 1;
    localparam int CNT_W  = 4;

    function automatic logic [AXIS_W-1:0] bin2gray(input logic [AXIS_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/qam_gray_map.sv
// Per-axis symbol mapper: Gray-codes I and Q when QAM_GRAY_EN is defined,
// otherwise passes the natural-binary symbol straight through.
module qam_gray_map
    import qam_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    output logic [SYM_W-1:0] o_sym
);

`ifdef QAM_GRAY_EN
    assign o_sym = {bin2gray(i_sym[SYM_W-1 -: AXIS_W]), bin2gray(i_sym[AXIS_W-1:0])};
`else
    assign o_sym = i_sym;
`endif

endmodule

// File: rtl/fifo_qam_symbol_reader.sv
// Pops bytes from the CDC FIFO read port and repacks them MSB-first into 6-bit
// 64-QAM symbols ({I,Q}) on a valid/ready port. Gray output under QAM_GRAY_EN.
module fifo_qam_symbol_reader #(
    parameter int DATA_W = 8,
    parameter int SYM_W  = 6
) (
    input  logic              read_clk,
    input  logic              read_rst,
    input  logic              empty,
    output logic              read_enable,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [SYM_W-1:0]  symbol,
    output logic              symbol_valid,
    input  logic              symbol_ready
);
    import qam_pkg::*;

    if (DATA_W != qam_pkg::DATA_W) begin : g_bad_data_w
        $error("fifo_qam_symbol_reader: DATA_W must be 8");
    end
    if ((SYM_W % 2) != 0 || SYM_W > DATA_W || SYM_W != qam_pkg::SYM_W) begin : g_bad_sym_w
        $error("fifo_qam_symbol_reader: SYM_W must be 6 (even, <= DATA_W)");
    end

    localparam logic [CNT_W-1:0] SYM_CNT  = CNT_W'(SYM_W);
    localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] REQ_MAX  = CNT_W'(SYM_W - 1);

    logic [BUF_W-1:0] r_bitbuf;
    logic [CNT_W-1:0] r_count;
    logic             r_pending;

    logic             w_valid;
    logic             w_fire;
    logic [CNT_W-1:0] w_eff;
    logic [CNT_W-1:0] w_shift;
    logic [BUF_W-1:0] w_aligned;
    logic [SYM_W-1:0] w_raw;
    logic [SYM_W-1:0] w_mapped;

    assign w_valid = (r_count >= SYM_CNT);
    assign w_fire  = w_valid & symbol_ready;
    assign w_eff   = r_count - (w_fire ? SYM_CNT : '0);

    // Requesting only when the post-fire fill is below one symbol bounds the
    // buffer at 5 + 8 = 13 bits and keeps a single read outstanding.
    assign read_enable = !empty && !r_pending && !read_rst && (w_eff <= REQ_MAX);

    // Oldest bit sits at r_count-1; shifting by r_count-6 lands the symbol at [5:0].
    assign w_shift   = r_count - SYM_CNT;
    assign w_aligned = r_bitbuf >> w_shift;
    assign w_raw     = w_aligned[SYM_W-1:0];

    qam_gray_map u_gray_map (
        .i_sym (w_raw),
        .o_sym (w_mapped)
    );

    assign symbol_valid = w_valid;
    assign symbol       = w_valid ? w_mapped : '0;

    always_ff @(posedge read_clk) begin
        // NOTE: reset wins over a pending capture, so a byte already popped from
        // the FIFO is dropped on purpose rather than landing in a fresh buffer.
        if (read_rst) begin
            r_bitbuf  <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_pending <= read_enable;
            if (r_pending) begin
                r_bitbuf <= {r_bitbuf[BUF_W-DATA_W-1:0], fifo_data};
                r_count  <= w_eff + BYTE_CNT;
            end else begin
                r_count  <= w_eff;
            end
        end
    end

endmodule

// File: tb/tb_fifo_qam_symbol_reader.sv
// Self-checking bench for fifo_qam_symbol_reader: a bit-queue model checked every
// cycle plus directed literal expectations; adapts to QAM_GRAY_EN when defined.
module tb_fifo_qam_symbol_reader;

    logic       read_clk = 1'b0;
    logic       read_rst = 1'b1;
    logic       empty;
    logic       read_enable;
    logic [7:0] fifo_data = 8'h00;
    logic [5:0] symbol;
    logic       symbol_valid;
    logic       symbol_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 read_clk = ~read_clk;

    fifo_qam_symbol_reader dut (
        .read_clk     (read_clk),
        .read_rst     (read_rst),
        .empty        (empty),
        .read_enable  (read_enable),
        .fifo_data    (fifo_data),
        .symbol       (symbol),
        .symbol_valid (symbol_valid),
        .symbol_ready (symbol_ready)
    );

    // FIFO storage model with a registered read port
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge read_clk) begin
        if (read_enable) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] gmap(input logic [5:0] s);
`ifdef QAM_GRAY_EN
        return {s[5:3] ^ (s[5:3] >> 1), s[2:0] ^ (s[2:0] >> 1)};
`else
        return s;
`endif
    endfunction

    // Behavioural model: the stream is a queue of bits, oldest first
    bit         m_bits[$];
    bit         m_inflight = 1'b0;
    logic [7:0] m_byte = 8'h00;

    function automatic bit m_valid();
        return m_bits.size() >= 6;
    endfunction

    function automatic logic [5:0] m_sym();
        logic [5:0] s;
        for (int i = 0; i < 6; i++) s[5-i] = m_bits[i];
        return gmap(s);
    endfunction

    function automatic bit m_re();
        int eff;
        eff = int'(m_bits.size()) - ((m_valid() && symbol_ready) ? 6 : 0);
        return !empty && !m_inflight && !read_rst && (eff <= 5);
    endfunction

    always @(posedge read_clk) begin
        if (read_rst) begin
            m_bits.delete();
            m_inflight = 1'b0;
        end else begin
            bit re;
            re = m_re();
            if (m_valid() && symbol_ready)
                for (int i = 0; i < 6; i++) void'(m_bits.pop_front());
            if (m_inflight)
                for (int i = 7; i >= 0; i--) m_bits.push_back(m_byte[i]);
            m_inflight = re;
            if (re) m_byte = mem[rd_ptr];
        end
    end

    // Per-cycle compare plus logs of what the DUT actually delivered
    logic [5:0] dut_log[$];
    int pop_cnt = 0;

    always @(negedge read_clk) begin
        check("symbol_valid", 32'(symbol_valid), 32'(m_valid()));
        check("read_enable", 32'(read_enable), 32'(m_re()));
        if (m_valid()) check("symbol", 32'(symbol), 32'(m_sym()));
        else           check("symbol_idle", 32'(symbol), 32'h0);
        if (symbol_valid && symbol_ready) dut_log.push_back(symbol);
        if (read_enable) pop_cnt++;
    end

    function automatic logic [5:0] sym_at(input int i);
        if (i < dut_log.size()) return dut_log[i];
        return 6'bx;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge read_clk);
        #2;
    endtask

    task automatic do_reset();
        read_rst = 1'b1;
        tick(2);
        read_rst = 1'b0;
        dut_log.delete();
        pop_cnt = 0;
    endtask

    task automatic wait_syms(input int n, input int budget);
        int k = 0;
        while (dut_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("syms_seen", 32'(dut_log.size() >= n), 32'h1);
    endtask

    logic [5:0] t1 [4];
    logic [5:0] t2 [6];
    logic [5:0] t3 [2];
    logic [5:0] t4 [2];

    initial begin
`ifdef QAM_GRAY_EN
        t1 = '{6'b111001, 6'b011010, 6'b101010, 6'b101000};
        t2 = '{6'b111001, 6'b011010, 6'b101010, 6'b101000, 6'b000110, 6'b110010};
        t3 = '{6'b100100, 6'b101000};
        t4 = '{6'b101000, 6'b101111};
`else
        t1 = '{6'b101001, 6'b010011, 6'b110011, 6'b110000};
        t2 = '{6'b101001, 6'b010011, 6'b110011, 6'b110000, 6'b000100, 6'b100011};
        t3 = '{6'b111111, 6'b110000};
        t4 = '{6'b110000, 6'b110101};
`endif
        tick(3);
        @(negedge read_clk);
        check("rst_count", 32'(dut.r_count), 32'h0);
        check("rst_bitbuf", 32'(dut.r_bitbuf), 32'h0);
        check("rst_pending", 32'(dut.r_pending), 32'h0);
        check("rst_valid", 32'(symbol_valid), 32'h0);
        check("rst_symbol", 32'(symbol), 32'h0);
        check("rst_read_enable", 32'(read_enable), 32'h0);
        tick(1);
        read_rst = 1'b0;
        dut_log.delete();
        pop_cnt = 0;

        // Binary/Gray repack of A5 3C F0
        symbol_ready = 1'b1;
        push(8'hA5); push(8'h3C); push(8'hF0);
        wait_syms(4, 100);
        tick(5);
        for (int i = 0; i < 4; i++) check($sformatf("repack_sym%0d", i), 32'(sym_at(i)), 32'(t1[i]));
        check("repack_pops", 32'(pop_cnt), 32'd3);
        check("repack_nsyms", 32'(dut_log.size()), 32'd4);
        check("repack_count", 32'(dut.r_count), 32'd0);

        // Backpressure with five bytes queued
        do_reset();
        symbol_ready = 1'b0;
        push(8'hA5); push(8'h3C); push(8'hF0); push(8'h12); push(8'h34);
        tick(5);
        check("stall_sym_early", 32'(symbol), 32'(t1[0]));
        tick(15);
        check("stall_pops", 32'(pop_cnt <= 2), 32'h1);
        check("stall_count", 32'(dut.r_count <= 13), 32'h1);
        check("stall_valid", 32'(symbol_valid), 32'h1);
        check("stall_sym_late", 32'(symbol), 32'(t1[0]));
        symbol_ready = 1'b1;
        wait_syms(6, 200);
        tick(5);
        for (int i = 0; i < 6; i++) check($sformatf("bp_sym%0d", i), 32'(sym_at(i)), 32'(t2[i]));
        check("bp_nsyms", 32'(dut_log.size()), 32'd6);
        check("bp_residual", 32'(dut.r_count), 32'd4);

        // Empty mid-stream, then a byte spanning the held residual
        do_reset();
        symbol_ready = 1'b1;
        push(8'hFF);
        tick(10);
        check("empty_nsyms", 32'(dut_log.size()), 32'd1);
        check("empty_sym0", 32'(sym_at(0)), 32'(t3[0]));
        check("empty_valid", 32'(symbol_valid), 32'h0);
        check("empty_count", 32'(dut.r_count), 32'd2);
        push(8'h00);
        begin
            bit found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge read_clk);
                found = dut.r_pending;
            end
            check("span_pending_seen", 32'(found), 32'h1);
            check("span_count_before", 32'(dut.r_count), 32'd2);
            @(negedge read_clk);
            check("span_count_after", 32'(dut.r_count), 32'd10);
            check("span_symbol", 32'(symbol), 32'(t3[1]));
        end
        tick(10);
        check("span_sym1", 32'(sym_at(1)), 32'(t3[1]));
        check("span_residual", 32'(dut.r_count), 32'd4);

        // Reset while a read is pending drops the in-flight byte
        do_reset();
        symbol_ready = 1'b1;
        push(8'h81);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge read_clk);
                seen = read_enable;
            end
            check("rstp_read_seen", 32'(seen), 32'h1);
        end
        @(posedge read_clk);
        #2;
        read_rst = 1'b1;
        @(negedge read_clk);
        check("rstp_pending_set", 32'(dut.r_pending), 32'h1);
        @(negedge read_clk);
        check("rstp_count", 32'(dut.r_count), 32'd0);
        check("rstp_valid", 32'(symbol_valid), 32'h0);
        check("rstp_pending_clr", 32'(dut.r_pending), 32'h0);
        tick(1);
        read_rst = 1'b0;
        dut_log.delete();
        push(8'hC3); push(8'h5A);
        wait_syms(2, 100);
        tick(5);
        for (int i = 0; i < 2; i++) check($sformatf("rstp_sym%0d", i), 32'(sym_at(i)), 32'(t4[i]));
        check("rstp_nsyms", 32'(dut_log.size()), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
